// File: rtl/sync_trigger_ctrl_pkg.sv
// Shared types for the trigger sequencer: FSM states, fault codes and
// the synchronizer depth used on every asynchronous input.
package sync_trig_pkg;

    localparam int SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        GATED,
        FIRE,
        WAIT_WIRE,
        DONE,
        FAULT
    } state_t;

    typedef enum logic [1:0] {
        NONE     = 2'd0,
        ARM_TO   = 2'd1,
        WIRE_TO  = 2'd2,
        SPURIOUS = 2'd3
    } fault_t;

endpackage

// File: rtl/sync_trigger_ctrl_if.sv
// Signal bundle between the trigger sequencer (slave) and the system/bench
// side that drives the asynchronous condition lines (master).
interface sync_trigger_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             start_condition;
    logic             abort;
    logic             fast_gate;
    logic             phase_signal;
    logic             wire_sensor;
    logic             output_trigger;
    logic             busy;
    logic             done;
    logic             fault;
    logic [1:0]       fault_code;
    logic [CNT_W-1:0] wire_delay;

    modport master (
        output start_condition, abort, fast_gate, phase_signal, wire_sensor,
        input  output_trigger, busy, done, fault, fault_code, wire_delay
    );

    modport slave (
        input  start_condition, abort, fast_gate, phase_signal, wire_sensor,
        output output_trigger, busy, done, fault, fault_code, wire_delay
    );
endinterface

// File: rtl/sync_trigger_ctrl_sync_edge.sv
// N-flop synchronizer followed by one registered stage that produces the
// clean level and single-cycle rise/fall strobes (3 clk latency with N=2).
module sync_edge
    import sync_trig_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            level  <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_in};
            level  <= sync_q[STAGES-1];
            rise   <= sync_q[STAGES-1] & ~level;
            fall   <= ~sync_q[STAGES-1] & level;
        end
    end

endmodule

// File: rtl/sync_trigger_ctrl.sv
// Trigger sequencer: arm on start, fire inside a fast-gate window, time the
// wire response. Define SYNC_TRIG_PHASE_ALIGN_EN to fire on a phase rise.
module sync_trigger_ctrl
    import sync_trig_pkg::*;
#(
    parameter int TRIG_LEN_CYC     = 10,
    parameter int ARM_TIMEOUT_CYC  = 2_000_000,
    parameter int WIRE_TIMEOUT_CYC = 1_000_000,
    parameter int CNT_W            = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    sync_trigger_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_LEN_CYC - 1);
    localparam logic [CNT_W-1:0] ARM_LAST  = CNT_W'(ARM_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] WIRE_LAST = CNT_W'(WIRE_TIMEOUT_CYC - 1);

    logic start_lvl, start_rise, start_fall;
    logic abort_lvl, abort_rise, abort_fall;
    logic gate_lvl, gate_rise, gate_fall;
    logic wire_lvl, wire_rise, wire_fall;

    sync_edge #(.STAGES(SYNC_STAGES)) u_start (
        .clk(clk), .rst_n(rst_n), .async_in(bus.start_condition),
        .level(start_lvl), .rise(start_rise), .fall(start_fall));
    sync_edge #(.STAGES(SYNC_STAGES)) u_abort (
        .clk(clk), .rst_n(rst_n), .async_in(bus.abort),
        .level(abort_lvl), .rise(abort_rise), .fall(abort_fall));
    sync_edge #(.STAGES(SYNC_STAGES)) u_gate (
        .clk(clk), .rst_n(rst_n), .async_in(bus.fast_gate),
        .level(gate_lvl), .rise(gate_rise), .fall(gate_fall));
    sync_edge #(.STAGES(SYNC_STAGES)) u_wire (
        .clk(clk), .rst_n(rst_n), .async_in(bus.wire_sensor),
        .level(wire_lvl), .rise(wire_rise), .fall(wire_fall));

`ifdef SYNC_TRIG_PHASE_ALIGN_EN
    logic phase_lvl, phase_rise, phase_fall;

    sync_edge #(.STAGES(SYNC_STAGES)) u_phase (
        .clk(clk), .rst_n(rst_n), .async_in(bus.phase_signal),
        .level(phase_lvl), .rise(phase_rise), .fall(phase_fall));

    logic unused_sig;
    assign unused_sig = &{1'b0, start_lvl, start_fall, abort_rise, abort_fall,
                          gate_lvl, wire_lvl, wire_fall, phase_lvl, phase_fall};
`else
    logic unused_sig;
    assign unused_sig = &{1'b0, start_lvl, start_fall, abort_rise, abort_fall,
                          gate_lvl, gate_fall, wire_lvl, wire_fall, bus.phase_signal};
`endif

    state_t           state_q, state_d;
    fault_t           code_q, code_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] delay_q, delay_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             hit_q, hit_d;
    logic             done_q, done_d;
    logic             fault_q, fault_d;
    logic             trig_q, trig_d;
    logic             busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        code_d  = code_q;
        delay_d = delay_q;
        pend_d  = pend_q;
        hit_d   = hit_q;
        done_d  = done_q;
        fault_d = fault_q;

        if (abort_lvl) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE, FAULT: begin
                    cnt_d = cnt_q;
                    if (start_rise) begin
                        state_d = ARMED;
                        cnt_d   = '0;
                        done_d  = 1'b0;
                        fault_d = 1'b0;
                        code_d  = NONE;
                    end
                end
                ARMED: begin
                    if (wire_rise) begin
                        state_d = FAULT;
                        fault_d = 1'b1;
                        code_d  = SPURIOUS;
                    end else if (cnt_q == ARM_LAST) begin
                        state_d = FAULT;
                        fault_d = 1'b1;
                        code_d  = ARM_TO;
                    end else if (gate_rise) begin
`ifdef SYNC_TRIG_PHASE_ALIGN_EN
                        state_d = GATED;
`else
                        state_d = FIRE;
                        cnt_d   = '0;
                        hit_d   = 1'b0;
`endif
                    end
                end
`ifdef SYNC_TRIG_PHASE_ALIGN_EN
                GATED: begin
                    if (wire_rise) begin
                        state_d = FAULT;
                        fault_d = 1'b1;
                        code_d  = SPURIOUS;
                    end else if (cnt_q == ARM_LAST) begin
                        state_d = FAULT;
                        fault_d = 1'b1;
                        code_d  = ARM_TO;
                    end else if (phase_rise) begin
                        state_d = FIRE;
                        cnt_d   = '0;
                        hit_d   = 1'b0;
                    end else if (gate_fall) begin
                        state_d = ARMED;
                    end
                end
`endif
                FIRE: begin
                    // An early wire break is remembered; the pulse always runs full width.
                    if (wire_rise && !hit_q) begin
                        hit_d  = 1'b1;
                        pend_d = cnt_q;
                    end
                    if (cnt_q == TRIG_LAST) begin
                        if (hit_d) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                            delay_d = pend_d;
                        end else begin
                            state_d = WAIT_WIRE;
                        end
                    end
                end
                WAIT_WIRE: begin
                    if (wire_rise) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        delay_d = cnt_q;
                    end else if (cnt_q == WIRE_LAST) begin
                        state_d = FAULT;
                        fault_d = 1'b1;
                        code_d  = WIRE_TO;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        trig_d = (state_d == FIRE);
        busy_d = (state_d == ARMED) || (state_d == GATED) ||
                 (state_d == FIRE)  || (state_d == WAIT_WIRE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            code_q  <= NONE;
            cnt_q   <= '0;
            delay_q <= '0;
            pend_q  <= '0;
            hit_q   <= 1'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            trig_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            delay_q <= delay_d;
            pend_q  <= pend_d;
            hit_q   <= hit_d;
            done_q  <= done_d;
            fault_q <= fault_d;
            trig_q  <= trig_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.output_trigger = trig_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.fault          = fault_q;
    assign bus.fault_code     = code_q;
    assign bus.wire_delay     = delay_q;

endmodule
